aes_key_sched_buf: RTL
======================

Name: aes_key_sched_buf

Overview:
AES-128 key schedule engine with round-key store. It sits directly downstream of aes_rcon and shares aes_rcon's kld strobe, consuming one rcon word per cycle. It expands a 128-bit cipher key into the 11 round keys over 10 cycles and holds all of them. It then streams them out to the round datapath under a valid/ready handshake, in reverse order for decryption or forward order for encryption.

Parameters:
None. AES-128 only, Nr = 10, 11 round keys.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
kld  in  1  key-load strobe, one cycle; same net that drives aes_rcon.kld
key_in  in  128  cipher key, sampled when kld=1; key_in[127:96] = w0
rcon_in  in  32  aes_rcon.out; only rcon_in[31:24] may be non-zero
key_ready  out  1  all 11 round keys stored and valid
rd_start  in  1  begin a stream; sampled only in READY
rd_dir  in  1  sampled with rd_start; 0 = slot 10 down to 0 (decrypt), 1 = slot 0 up to 10 (encrypt)
rk_out  out  128  current round key
rk_valid  out  1  rk_out valid
rk_ready  in  1  consumer accepts rk_out
rk_last  out  1  rk_out is the 11th key of the stream

Behaviour:
- Reset (rst=1 at an edge): state IDLE; key_ready=0, rk_valid=0, rk_last=0, rk_out=0. Slot storage is not cleared. rst has priority over every other input.
- States: IDLE, EXPAND, READY, STREAM.
- kld=1 at an edge, in any state: w <= key_in, slot0 <= key_in, rnd <= 1, state <= EXPAND, key_ready <= 0, rk_valid <= 0, rk_last <= 0.
  - An in-progress expansion or stream is aborted.
  - kld has priority over rd_start.
- EXPAND: each edge computes and stores one key.
  - temp = SubWord(RotWord(w3)) ^ rcon_in. RotWord(x) = {x[23:0], x[31:24]}. SubWord uses four aes_sbox instances, combinational.
  - w0' = w0^temp, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - Edge k (k = 1..10) after kld stores slot k and loads w.
  - Timing match: aes_rcon presents rcon for round k (01, 02, ... 36) during the cycle before edge k.
  - At edge 10: state <= READY, key_ready <= 1. Latency kld to key_ready = 10 cycles.
- READY: key_ready=1. rd_start=1 at an edge:
  - state <= STREAM.
  - rk_out <= first slot (10 if rd_dir=0, 0 if rd_dir=1).
  - rk_valid <= 1; pointer set to the next slot.
  - rk_last <= 0.
- STREAM:
  - rk_out and rk_last hold stable while rk_valid=1 and rk_ready=0.
  - On accept (rk_valid & rk_ready) of a non-last key: rk_out <= next slot, pointer advances by ±1. rk_last <= 1 when the newly loaded key is the 11th.
  - On accept with rk_last=1: rk_valid <= 0, rk_last <= 0, state <= READY.
  - Exactly 11 accepts per stream; one key per cycle when rk_ready is held high.
  - rd_start is ignored in STREAM, EXPAND and IDLE.
- key_ready stays 1 through any number of streams until the next kld or rst.
- rk_out is registered; no combinational path from rk_ready to rk_out.

Test Plan:
- Expansion (FIPS-197 A.1): rst; kld with key_in = 2b7e151628aed2a6abf7158809cf4f3c, aes_rcon driving rcon_in. key_ready rises exactly 10 cycles after the kld edge. slot1 = a0fafe1788542cb123a339392a6c7605; slot10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Reverse stream, rk_ready held 1: rd_start with rd_dir=0 -> 11 consecutive valid cycles.
  - First rk_out = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Last rk_out = 2b7e1516...4f3c with rk_last=1.
  - rk_valid=0 on the following cycle.
- Forward stream with backpressure (rk_ready random ~50%): rd_dir=1 -> keys 0..10 in order, each held stable while stalled, no key dropped or duplicated. A second rd_start replays identically.
- kld mid-stream after 4 accepts, new key 000102030405060708090a0b0c0d0e0f: next cycle rk_valid=0 and key_ready=0. 10 cycles later slot10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Priority: rd_start during EXPAND is ignored. kld and rd_start in the same READY cycle -> expansion restarts with no stream. rst and kld together -> IDLE with all outputs 0.

Source files
------------

// File: rtl/aes_key_sched_buf.sv
// AES-128 key schedule engine with an 11-entry round-key store.
// Expands the cipher key one round key per cycle, using the rcon word from
// aes_rcon. It then streams the stored keys out over a valid/ready handshake,
// either forward (encrypt) or reverse (decrypt).

module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ aa;
            end else begin
                acc = acc;
            end
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    // S-box affine transform applied to the field inverse
    function automatic logic [7:0] sbox_fn(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Combinational substitution
    always_comb begin
        out_byte = sbox_fn(in_byte);
    end

endmodule

module aes_key_sched_buf (
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic [127:0] key_in,
    input  logic [31:0]  rcon_in,
    output logic         key_ready,
    input  logic         rd_start,
    input  logic         rd_dir,
    output logic [127:0] rk_out,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         rk_last
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_READY  = 2'd2,
        S_STREAM = 2'd3
    } state_t;

    state_t       state_r;
    state_t       next_state_s;
    logic [127:0] w_r;
    logic [127:0] slot_r [0:10];
    logic [3:0]   rnd_r;
    logic [3:0]   ptr_r;
    logic         dir_r;
    logic         key_ready_r;
    logic         rk_valid_r;
    logic         rk_last_r;
    logic [127:0] rk_out_r;

    logic [31:0]  rot_s;
    logic [31:0]  sub_s;
    logic [31:0]  temp_s;
    logic [127:0] w_next_s;
    logic         accept_s;

    assign rot_s = {w_r[23:0], w_r[31:24]};

    aes_sbox u_sbox0 (.in_byte(rot_s[31:24]), .out_byte(sub_s[31:24]));
    aes_sbox u_sbox1 (.in_byte(rot_s[23:16]), .out_byte(sub_s[23:16]));
    aes_sbox u_sbox2 (.in_byte(rot_s[15:8]),  .out_byte(sub_s[15:8]));
    aes_sbox u_sbox3 (.in_byte(rot_s[7:0]),   .out_byte(sub_s[7:0]));

    // One round of key expansion from the current working words
    always_comb begin
        temp_s            = sub_s ^ rcon_in;
        w_next_s[127:96]  = w_r[127:96] ^ temp_s;
        w_next_s[95:64]   = w_r[95:64]  ^ w_next_s[127:96];
        w_next_s[63:32]   = w_r[63:32]  ^ w_next_s[95:64];
        w_next_s[31:0]    = w_r[31:0]   ^ w_next_s[63:32];
    end

    assign accept_s = rk_valid_r & rk_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; kld restarts expansion from any state
    always_comb begin
        next_state_s = state_r;
        if (kld) begin
            next_state_s = S_EXPAND;
        end else begin
            case (state_r)
                S_IDLE:   next_state_s = S_IDLE;
                S_EXPAND: next_state_s = (rnd_r == 4'd10) ? S_READY : S_EXPAND;
                S_READY:  next_state_s = rd_start ? S_STREAM : S_READY;
                S_STREAM: next_state_s = (accept_s && rk_last_r) ? S_READY : S_STREAM;
                default:  next_state_s = S_IDLE;
            endcase
        end
    end

    // Round-key store; deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_r[0] <= slot_r[0];
        end else if (kld) begin
            slot_r[0] <= key_in;
        end else if (state_r == S_EXPAND) begin
            slot_r[rnd_r] <= w_next_s;
        end else begin
            slot_r[0] <= slot_r[0];
        end
    end

    // Expansion working state, stream pointer and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            key_ready_r <= 1'b0;
            rk_valid_r  <= 1'b0;
            rk_last_r   <= 1'b0;
            rk_out_r    <= 128'h0;
            rnd_r       <= 4'd0;
            ptr_r       <= 4'd0;
            dir_r       <= 1'b0;
            w_r         <= 128'h0;
        end else if (kld) begin
            w_r         <= key_in;
            rnd_r       <= 4'd1;
            key_ready_r <= 1'b0;
            rk_valid_r  <= 1'b0;
            rk_last_r   <= 1'b0;
        end else begin
            case (state_r)
                S_EXPAND: begin
                    w_r   <= w_next_s;
                    rnd_r <= rnd_r + 4'd1;
                    if (rnd_r == 4'd10) begin
                        key_ready_r <= 1'b1;
                    end else begin
                        key_ready_r <= 1'b0;
                    end
                end
                S_READY: begin
                    if (rd_start) begin
                        dir_r      <= rd_dir;
                        rk_out_r   <= rd_dir ? slot_r[0] : slot_r[10];
                        ptr_r      <= rd_dir ? 4'd1 : 4'd9;
                        rk_valid_r <= 1'b1;
                        rk_last_r  <= 1'b0;
                    end else begin
                        rk_valid_r <= 1'b0;
                    end
                end
                S_STREAM: begin
                    if (accept_s && rk_last_r) begin
                        rk_valid_r <= 1'b0;
                        rk_last_r  <= 1'b0;
                    end else if (accept_s) begin
                        rk_out_r  <= slot_r[ptr_r];
                        // The key at the end slot is the 11th of the stream
                        rk_last_r <= dir_r ? (ptr_r == 4'd10) : (ptr_r == 4'd0);
                        if ((dir_r && ptr_r != 4'd10) || (!dir_r && ptr_r != 4'd0)) begin
                            ptr_r <= dir_r ? (ptr_r + 4'd1) : (ptr_r - 4'd1);
                        end else begin
                            ptr_r <= ptr_r;
                        end
                    end else begin
                        rk_out_r <= rk_out_r;
                    end
                end
                default: begin
                    rk_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign key_ready = key_ready_r;
    assign rk_valid  = rk_valid_r;
    assign rk_last   = rk_last_r;
    assign rk_out    = rk_out_r;

endmodule
